// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative restoring divider. Produces the quotient and remainder
//            of A / B, one quotient bit per clock, using a start/busy/done
//            handshake so that one division is in flight at a time.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     operand, quotient and remainder width in bits (>= 2)
// Ports
//   CLK       input   1      system clock, rising-edge active
//   RST       input   1      asynchronous active-low reset
//   START     input   1      request a division (sampled only when idle)
//   A         input   WIDTH  dividend, captured on an accepted START
//   B         input   WIDTH  divisor, captured on an accepted START
//   BUSY      output  1      high while a division is in progress
//   DONE      output  1      one-cycle pulse when Q/R/DIV_ZERO are updated
//   Q         output  WIDTH  quotient (held until the next result)
//   R         output  WIDTH  remainder (held until the next result)
//   DIV_ZERO  output  1      set together with DONE when captured B was 0
// Configuration
//   SEQ_DIVIDER_SIGNED_EN  when defined, A and B are two's complement.
//                          Magnitudes go through the same unsigned core and
//                          the signs are applied when the result is
//                          registered, so latency does not change.
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIV_ZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;

  // FSM-derived controls
  logic             accept;
  logic             iterate;
  logic             finish;

  // Datapath registers
  logic [WIDTH-1:0] dvd;       // dividend, shifted out MSB-first; becomes quotient
  logic [WIDTH-1:0] dvs;       // captured divisor (magnitude in signed mode)
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [CW-1:0]    cnt;       // iterations still to run
  logic             zero_div;  // captured divisor was zero

  // Operand values loaded into the core on an accepted START
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;

  // Per-iteration datapath
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;

  // Values registered into Q/R when leaving FINISH
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             a_neg;
  logic             b_neg;

  // Two's-complement magnitude; -2^(WIDTH-1) maps to itself, which the
  // unsigned core reads correctly as 2^(WIDTH-1).
  assign a_in = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_in = B[WIDTH-1] ? (~B + 1'b1) : B;
`else
  assign a_in = A;
  assign b_in = B;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          // A zero divisor skips the iterations entirely.
          state_next = (B == '0) ? S_FINISH : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == CW'(1)) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    BUSY    = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        // The cycle in which DONE is high is still idle, but a START there
        // is deliberately ignored so that back-to-back issue needs one gap.
        accept = START && !DONE;
      end
      S_CALC: begin
        BUSY    = 1'b1;
        iterate = 1'b1;
      end
      S_FINISH: begin
        BUSY   = 1'b1;
        finish = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One restoring-division step.
  // The shifted remainder is kept at WIDTH+1 bits: with a divisor above
  // 2^(WIDTH-1) the partial remainder can reach WIDTH bits, and dropping its
  // MSB on the shift would corrupt the trial subtraction. The extra top bit
  // of trial is the borrow.
  // --------------------------------------------------------------------------
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs};
  assign trial_ok = !trial[WIDTH+1];
  // Either branch is provably below the divisor, so WIDTH bits suffice.
  assign rem_next = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Result formatting
  // --------------------------------------------------------------------------
`ifdef SEQ_DIVIDER_SIGNED_EN
  always_comb begin
    res_q = '1;
    res_r = '0;
    if (zero_div) begin
      // dvd still holds |A|; re-apply the sign to return A itself.
      res_q = '1;
      res_r = a_neg ? (~dvd + 1'b1) : dvd;
    end else begin
      // Truncation toward zero; remainder follows the dividend's sign.
      res_q = (a_neg ^ b_neg) ? (~dvd + 1'b1) : dvd;
      res_r = a_neg ? (~rem + 1'b1) : rem;
    end
  end
`else
  always_comb begin
    res_q = '1;
    res_r = '0;
    if (zero_div) begin
      // No iterations ran, so dvd still holds the captured dividend.
      res_q = '1;
      res_r = dvd;
    end else begin
      res_q = dvd;
      res_r = rem;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      zero_div <= 1'b0;
      DONE     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      DIV_ZERO <= 1'b0;
    end else begin
      DONE <= finish;

      if (accept) begin
        dvd      <= a_in;
        dvs      <= b_in;
        rem      <= '0;
        cnt      <= CW'(WIDTH);
        // Internal flag only; the visible DIV_ZERO keeps the previous
        // result until this operation finishes.
        zero_div <= (B == '0);
      end else if (iterate) begin
        rem <= rem_next;
        dvd <= {dvd[WIDTH-2:0], trial_ok};
        cnt <= cnt - 1'b1;
      end

      if (finish) begin
        Q        <= res_q;
        R        <= res_r;
        DIV_ZERO <= zero_div;
      end
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_neg <= 1'b0;
      b_neg <= 1'b0;
    end else if (accept) begin
      a_neg <= A[WIDTH-1];
      b_neg <= B[WIDTH-1];
    end
  end
`endif

endmodule
`default_nettype wire
